// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port A (CPU) normally wins, port B (loader/debug)
// is promoted after MAX_WAIT lost arbitrations. One access per two cycles.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_2000,
  parameter int          MEM_WORDS = 8192,
  parameter int          MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_we,
  input  logic [2:0]  a_fn3,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_we,
  input  logic [2:0]  b_fn3,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic [2:0]  mem_fn3,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0]    S_IDLE     = 1'b0;
  localparam logic [0:0]    S_RESP     = 1'b1;
  localparam int            WW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [32:0]   SPAN       = 33'(longint'(MEM_WORDS) * 4);

  logic [0:0]    r_state;
  logic [WW-1:0] r_waitCnt;
  logic          r_ownerB;
  logic          r_isLoad;
  logic          r_err;
  logic [31:0]   r_addr;
  logic [2:0]    r_fn3;

  logic        w_idle;
  logic        w_resp;
  logic        w_bWins;
  logic        w_aGnt;
  logic        w_bGnt;
  logic        w_gnt;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic [2:0]  w_fn3;
  logic [32:0] w_offset;
  logic        w_inRange;
  logic        w_alignOk;
  logic        w_fnOk;
  logic        w_legal;
  logic [31:0] w_rdata;

  // Grants are combinational and must stay quiet while reset is held.
  assign w_idle  = (r_state == S_IDLE) && !rst;
  assign w_resp  = (r_state == S_RESP);
  assign w_bWins = b_req && (!a_req || (r_waitCnt == WAIT_LIMIT));
  assign w_aGnt  = w_idle && a_req && !w_bWins;
  assign w_bGnt  = w_idle && w_bWins;
  assign w_gnt   = w_aGnt || w_bGnt;

  assign w_addr  = w_bWins ? b_addr  : a_addr;
  assign w_wdata = w_bWins ? b_wdata : a_wdata;
  assign w_we    = w_bWins ? b_we    : a_we;
  assign w_fn3   = w_bWins ? b_fn3   : a_fn3;

  // A borrow into bit 32 means the address lies below BASE_ADDR.
  assign w_offset  = {1'b0, w_addr} - {1'b0, BASE_ADDR};
  assign w_inRange = !w_offset[32] && (w_offset < SPAN);

  always_comb begin
    w_alignOk = 1'b1;
    case (w_fn3[1:0])
      2'b01:   w_alignOk = !w_addr[0];
      2'b10:   w_alignOk = (w_addr[1:0] == 2'b00);
      2'b11:   w_alignOk = 1'b0;
      default: w_alignOk = 1'b1;
    endcase
  end

  always_comb begin
    w_fnOk = 1'b0;
    case (w_fn3)
      3'b000, 3'b001, 3'b010: w_fnOk = 1'b1;
      3'b100, 3'b101:         w_fnOk = !w_we;
      default:                w_fnOk = 1'b0;
    endcase
  end

  assign w_legal = w_inRange && w_alignOk && w_fnOk;

  assign a_gnt     = w_aGnt;
  assign b_gnt     = w_bGnt;
  assign mem_addr  = w_gnt ? w_addr : (w_resp ? r_addr : 32'h0);
  assign mem_fn3   = w_gnt ? w_fn3  : (w_resp ? r_fn3  : 3'b000);
  assign mem_wdata = w_gnt ? w_wdata : 32'h0;
  assign mem_wr_en = w_gnt && w_we && w_legal;

  assign w_rdata  = (r_isLoad && !r_err) ? mem_rdata : 32'h0;
  assign a_rvalid = w_resp && !r_ownerB;
  assign b_rvalid = w_resp && r_ownerB;
  assign a_rdata  = a_rvalid ? w_rdata : 32'h0;
  assign b_rdata  = b_rvalid ? w_rdata : 32'h0;
  assign a_err    = a_rvalid && r_err;
  assign b_err    = b_rvalid && r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ownerB <= 1'b0;
      r_isLoad <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= 32'h0;
      r_fn3    <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_state  <= S_RESP;
            r_ownerB <= w_bWins;
            r_isLoad <= !w_we;
            r_err    <= !w_legal;
            r_addr   <= w_addr;
            r_fn3    <= w_fn3;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counts B's consecutive lost arbitrations; response cycles neither add nor clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= '0;
    end else if (!b_req || w_bGnt) begin
      r_waitCnt <= '0;
    end else if (w_idle && (r_waitCnt != WAIT_LIMIT)) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural data memory, a transaction-level reference
// model of arbitration and access legality, directed scenarios and random traffic.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h8000_2000;
  localparam int          WORDS = 8192;
  localparam int          MAXW  = 4;

  logic        clk, rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [2:0]  a_fn3, b_fn3;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_wr_en;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_fn3;

  dmem_arbiter #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_fn3(a_fn3),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we), .b_fn3(b_fn3),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_fn3(mem_fn3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          compareCount = 0;
  int          mismatchCount = 0;
  logic [31:0] envMem [WORDS];
  logic [31:0] refMem [WORDS];
  logic [31:0] rawWord;

  bit          respPending;
  int          bLost;
  bit          expOwnerB, expErr;
  logic [31:0] expRdata, expAddr;
  logic [2:0]  expFn3;
  bit          grantA, grantB, obsGntA, obsGntB;
  bit          aPend, bPend;
  logic [31:0] lastRdata;
  logic        lastErr;
  int          wrEnSeen, aRvalidSeen;

  function automatic logic [31:0] seedWord(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic int wordIndex(logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 2;
    return int'(off & 32'(WORDS - 1));
  endfunction

  function automatic logic [31:0] fmtLoad(logic [31:0] word, logic [1:0] off, logic [2:0] fn3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (fn3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] storeMerge(logic [31:0] word, logic [1:0] off,
                                             logic [2:0] fn3, logic [31:0] wdata);
    logic [31:0] w;
    w = word;
    case (fn3)
      3'b000:  w[8*off +: 8] = wdata[7:0];
      3'b001:  if (off[1]) w[31:16] = wdata[15:0]; else w[15:0] = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Legality from first principles: byte window, natural alignment, RV32 funct3 set.
  function automatic bit isLegal(logic [31:0] addr, logic we, logic [2:0] fn3);
    longint a, lo, hi, size;
    bit     fnOk;
    a    = {32'h0, addr};
    lo   = {32'h0, BASE};
    hi   = lo + 4 * WORDS;
    size = longint'(1) << fn3[1:0];
    fnOk = we ? (fn3 inside {3'd0, 3'd1, 3'd2}) : (fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return (a >= lo) && (a < hi) && ((a % size) == 0) && fnOk;
  endfunction

  // Data memory: captures the addressed word at the grant edge, formats combinationally.
  always @(posedge clk) begin
    rawWord <= envMem[wordIndex(mem_addr)];
    if (mem_wr_en)
      envMem[wordIndex(mem_addr)] = storeMerge(envMem[wordIndex(mem_addr)], mem_addr[1:0],
                                               mem_fn3, mem_wdata);
  end
  assign mem_rdata = fmtLoad(rawWord, mem_addr[1:0], mem_fn3);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_wr_en}, 0);
    checkOutput({tag, "_a_rdata"}, a_rdata, 0);
    checkOutput({tag, "_b_rdata"}, b_rdata, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_mem_fn3"}, mem_fn3, 0);
  endtask

  task automatic modelStep();
    bit          bWin, we, legal;
    logic [31:0] addr, wdata;
    logic [2:0]  fn3;
    int          idx;
    grantA = 0;
    grantB = 0;
    obsGntA = a_gnt;
    obsGntB = b_gnt;
    wrEnSeen += int'(mem_wr_en);
    aRvalidSeen += int'(a_rvalid);
    if (respPending) begin
      checkOutput("resp_gnt", {a_gnt, b_gnt, mem_wr_en}, 0);
      checkOutput("resp_rvalid", {a_rvalid, b_rvalid}, expOwnerB ? 2'b01 : 2'b10);
      checkOutput("resp_mem_addr", mem_addr, expAddr);
      checkOutput("resp_mem_fn3", mem_fn3, expFn3);
      if (expOwnerB) begin
        lastRdata = b_rdata;
        lastErr   = b_err;
        checkOutput("resp_other_port", a_rdata | 32'(a_err), 0);
      end else begin
        lastRdata = a_rdata;
        lastErr   = a_err;
        checkOutput("resp_other_port", b_rdata | 32'(b_err), 0);
      end
      checkOutput("resp_rdata", lastRdata, expRdata);
      checkOutput("resp_err", lastErr, expErr);
      if (!b_req) bLost = 0;
      respPending = 0;
    end else if (a_req || b_req) begin
      bWin  = b_req && (!a_req || bLost == MAXW);
      addr  = bWin ? b_addr : a_addr;
      wdata = bWin ? b_wdata : a_wdata;
      we    = bWin ? b_we : a_we;
      fn3   = bWin ? b_fn3 : a_fn3;
      legal = isLegal(addr, we, fn3);
      checkOutput("gnt", {a_gnt, b_gnt}, bWin ? 2'b01 : 2'b10);
      checkOutput("mem_addr", mem_addr, addr);
      checkOutput("mem_wdata", mem_wdata, wdata);
      checkOutput("mem_fn3", mem_fn3, fn3);
      checkOutput("mem_wr_en", mem_wr_en, we && legal);
      checkOutput("grant_no_rvalid", {a_rvalid, b_rvalid, a_err, b_err}, 0);
      expOwnerB = bWin;
      expAddr   = addr;
      expFn3    = fn3;
      expErr    = !legal;
      expRdata  = 0;
      if (legal) begin
        idx = wordIndex(addr);
        if (we) refMem[idx] = storeMerge(refMem[idx], addr[1:0], fn3, wdata);
        else expRdata = fmtLoad(refMem[idx], addr[1:0], fn3);
      end
      if (bWin) bLost = 0;
      else if (b_req) bLost = (bLost < MAXW) ? bLost + 1 : MAXW;
      else bLost = 0;
      respPending = 1;
      grantA = !bWin;
      grantB = bWin;
    end else begin
      checkOutput("idle_quiet", {a_gnt, b_gnt, mem_wr_en, a_rvalid, b_rvalid, a_err, b_err}, 0);
      bLost = 0;
    end
  endtask

  task automatic stepCycle();
    #1;
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randFields(output logic [31:0] addr, output logic we,
                            output logic [31:0] wdata, output logic [2:0] fn3);
    int sel;
    sel   = $urandom_range(0, 9);
    we    = 1'($urandom_range(0, 1));
    wdata = $urandom;
    case (sel)
      6:       addr = BASE - 32'($urandom_range(1, 4));
      7:       addr = BASE + 32'(4 * WORDS) - 4 + 32'($urandom_range(0, 7));
      8:       addr = 32'h8000_A000 + 32'($urandom_range(0, 3));
      9:       addr = $urandom;
      default: addr = BASE + 32'($urandom_range(0, 63));
    endcase
    if ($urandom_range(0, 3) == 0) fn3 = 3'($urandom_range(0, 7));
    else if (we) fn3 = 3'($urandom_range(0, 2));
    else begin
      fn3 = 3'($urandom_range(0, 4));
      if (fn3 == 3'd3) fn3 = 3'd5;
    end
    if ($urandom_range(0, 1) == 1) begin
      if (fn3[1:0] == 2'b01) addr[0] = 1'b0;
      else if (fn3[1:0] == 2'b10) addr[1:0] = 2'b00;
    end
  endtask

  task automatic applyStimulus(input int reqPct, input int dropPct);
    if (grantA) aPend = 0;
    if (grantB) bPend = 0;
    if (aPend && ($urandom_range(0, 99) < dropPct)) begin
      a_req = 0;
      aPend = 0;
    end else if (!aPend) begin
      if ($urandom_range(0, 99) < reqPct) begin
        randFields(a_addr, a_we, a_wdata, a_fn3);
        a_req = 1;
        aPend = 1;
      end else a_req = 0;
    end
    if (bPend && ($urandom_range(0, 99) < dropPct)) begin
      b_req = 0;
      bPend = 0;
    end else if (!bPend) begin
      if ($urandom_range(0, 99) < reqPct) begin
        randFields(b_addr, b_we, b_wdata, b_fn3);
        b_req = 1;
        bPend = 1;
      end else b_req = 0;
    end
  endtask

  task automatic applyDirected(input bit portB, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] fn3);
    bit granted;
    a_req = 0;
    b_req = 0;
    if (portB) begin
      b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; b_fn3 = fn3;
    end else begin
      a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; a_fn3 = fn3;
    end
    granted = 0;
    for (int i = 0; i < 8 && !granted; i++) begin
      stepCycle();
      granted = portB ? obsGntB : obsGntA;
    end
    if (!granted) checkOutput("directed_grant_timeout", 0, 1);
    a_req = 0;
    b_req = 0;
    aPend = 0;
    bPend = 0;
    stepCycle();
  endtask

  initial begin
    int          wr0, av0, nGrants, nB;
    logic [9:0]  seq;
    rst = 1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_fn3 = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_fn3 = 0;
    for (int i = 0; i < WORDS; i++) begin
      envMem[i] = seedWord(i);
      refMem[i] = seedWord(i);
    end
    respPending = 0; bLost = 0; wrEnSeen = 0; aRvalidSeen = 0;
    aPend = 0; bPend = 0; grantA = 0; grantB = 0;

    // Requests present while reset is held must be ignored.
    repeat (2) @(negedge clk);
    a_req = 1; a_we = 1; a_addr = BASE + 4; a_wdata = 32'h1234_5678; a_fn3 = 3'd2;
    b_req = 1; b_we = 0; b_addr = BASE + 8; b_fn3 = 3'd2;
    #1 checkAllZero("reset_held");
    @(negedge clk);
    rst = 0;

    wr0 = wrEnSeen;
    applyDirected(0, 1, 32'h8000_2004, 32'hDEAD_BEEF, 3'd2);
    checkOutput("sw_wr_en_once", 32'(wrEnSeen - wr0), 1);
    checkOutput("sw_err", lastErr, 0);
    applyDirected(0, 0, 32'h8000_2004, 32'h0, 3'd2);
    checkOutput("lw_rdata", lastRdata, 32'hDEAD_BEEF);
    checkOutput("lw_err", lastErr, 0);

    wr0 = wrEnSeen;
    applyDirected(0, 0, 32'h8000_A000, 32'h0, 3'd2);
    checkOutput("oor_err", lastErr, 1);
    checkOutput("oor_rdata", lastRdata, 0);
    applyDirected(0, 0, 32'h8000_2001, 32'h0, 3'd1);
    checkOutput("misalign_err", lastErr, 1);
    checkOutput("misalign_rdata", lastRdata, 0);
    applyDirected(0, 0, 32'h8000_2008, 32'h0, 3'd3);
    checkOutput("badfn3_err", lastErr, 1);
    checkOutput("badfn3_rdata", lastRdata, 0);
    applyDirected(0, 0, BASE - 1, 32'h0, 3'd0);
    checkOutput("below_base_err", lastErr, 1);
    checkOutput("illegal_no_wr_en", 32'(wrEnSeen - wr0), 0);

    av0 = aRvalidSeen;
    applyDirected(1, 1, 32'h8000_2003, 32'hABCD_EF12, 3'd0);
    applyDirected(1, 0, 32'h8000_2003, 32'h0, 3'd4);
    checkOutput("b_lbu_rdata", lastRdata, 32'h0000_0012);
    checkOutput("b_no_a_rvalid", 32'(aRvalidSeen - av0), 0);

    // Reset arriving during the response cycle of an A load.
    a_req = 1; a_we = 0; a_addr = BASE + 8; a_fn3 = 3'd2; b_req = 0;
    stepCycle();
    rst = 1;
    #1 checkAllZero("reset_in_resp");
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    respPending = 0;
    bLost = 0;
    stepCycle();
    checkOutput("grant_after_reset", obsGntA, 1);
    a_req = 0;
    stepCycle();

    // Both ports requesting continuously: B is promoted every fifth grant.
    a_req = 0; b_req = 0; aPend = 0; bPend = 0;
    stepCycle();
    stepCycle();
    nGrants = 0; nB = 0; seq = '0;
    repeat (50) begin
      applyStimulus(100, 0);
      stepCycle();
      if (obsGntA || obsGntB) begin
        if (obsGntB && nGrants < 10) seq[nGrants] = 1'b1;
        if (obsGntB) nB++;
        nGrants++;
      end
    end
    checkOutput("fair_order", seq, 10'b10_0001_0000);
    checkOutput("fair_total", nGrants, 25);
    checkOutput("fair_b_share", nB, 5);

    repeat (1500) begin
      applyStimulus(40, 8);
      stepCycle();
    end
    repeat (400) begin
      applyStimulus(90, 2);
      stepCycle();
    end

    a_req = 0; b_req = 0;
    stepCycle();
    stepCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
